execute_ex_mem: RTL and testbench

EXECUTE_EX_MEM -- requirements
Module: execute_ex_mem

---
 rtl/execute_ex_mem.sv | 186 ++++++++++++++++++
 tb/tb_execute_ex_mem.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/execute_ex_mem.sv
// EX stage with forwarding and EX/MEM pipeline register; iterative multiplier
// present only when EXECUTE_MUL_EN is defined (otherwise opcode 6 is a NOP).
module execute_ex_mem #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] instructionPropagation,
  input  logic [19:0] dataRFOut1,
  input  logic [19:0] dataRFOut2,
  input  logic [3:0]  ID_EX_op1,
  input  logic [3:0]  ID_EX_op2,
  input  logic [3:0]  opDestino,
  input  logic [3:0]  MEM_WB_rd,
  input  logic        MEM_WB_regwrite,
  input  logic [19:0] MEM_WB_data,
  output logic [19:0] EX_MEM_instruction,
  output logic [19:0] EX_MEM_result,
  output logic [19:0] EX_MEM_store_data,
  output logic [3:0]  EX_MEM_rd,
  output logic        EX_MEM_regwrite,
  output logic        EX_MEM_memread,
  output logic        EX_MEM_memwrite,
  output logic        stall_out
);
  if (MUL_CYCLES != 1 && MUL_CYCLES != 2 && MUL_CYCLES != 4 && MUL_CYCLES != 5) begin : g_bad_cfg
    $error("MUL_CYCLES must be 1, 2, 4 or 5");
  end

  localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR = 4'h4,
                         OP_SLT = 4'h5, OP_MUL = 4'h6, OP_LD = 4'h7, OP_ST = 4'h8;

  logic [3:0]  opcode, imm;
  logic [19:0] fwd_a, fwd_b;
  logic [19:0] alu_res;
  logic        alu_valid, alu_mr, alu_mw;

  logic [19:0] instr_q, instr_d, result_q, result_d, store_q, store_d;
  logic [3:0]  rd_q, rd_d;
  logic        rw_q, rw_d, mr_q, mr_d, mw_q, mw_d;

  assign opcode = instructionPropagation[19:16];
  assign imm    = instructionPropagation[3:0];

  // EX/MEM has priority over MEM/WB; r0 is never forwarded
  always_comb begin
    fwd_a = dataRFOut1;
    if (rw_q && rd_q == ID_EX_op1 && ID_EX_op1 != 4'd0) fwd_a = result_q;
    else if (MEM_WB_regwrite && MEM_WB_rd == ID_EX_op1 && ID_EX_op1 != 4'd0) fwd_a = MEM_WB_data;
    fwd_b = dataRFOut2;
    if (rw_q && rd_q == ID_EX_op2 && ID_EX_op2 != 4'd0) fwd_b = result_q;
    else if (MEM_WB_regwrite && MEM_WB_rd == ID_EX_op2 && ID_EX_op2 != 4'd0) fwd_b = MEM_WB_data;
  end

  always_comb begin
    alu_res   = 20'd0;
    alu_valid = 1'b1;
    alu_mr    = 1'b0;
    alu_mw    = 1'b0;
    case (opcode)
      OP_ADD:  alu_res = fwd_a + fwd_b;
      OP_SUB:  alu_res = fwd_a - fwd_b;
      OP_AND:  alu_res = fwd_a & fwd_b;
      OP_OR:   alu_res = fwd_a | fwd_b;
      OP_SLT:  alu_res = {19'd0, ($signed(fwd_a) < $signed(fwd_b))};
      OP_LD:   begin alu_res = fwd_a + {16'd0, imm}; alu_mr = 1'b1; end
      OP_ST:   begin alu_res = fwd_a + {16'd0, imm}; alu_mw = 1'b1; end
      default: alu_valid = 1'b0;
    endcase
  end

`ifdef EXECUTE_MUL_EN
  localparam int BITS = 20 / MUL_CYCLES;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  count_q, count_d;
  logic [19:0] prod_q, prod_d, a_q, a_d, b_q, b_d, mul_instr_q, mul_instr_d;
  logic [3:0]  mul_rd_q, mul_rd_d;

  assign stall_out = !reset && ((state_q == IDLE && opcode == OP_MUL) || state_q == BUSY);
`else
  assign stall_out = 1'b0;
`endif

  always_comb begin
    instr_d  = instructionPropagation;
    result_d = alu_res;
    store_d  = alu_mw ? fwd_b : 20'd0;
    rd_d     = alu_valid ? opDestino : 4'd0;
    rw_d     = alu_valid && !alu_mw && opDestino != 4'd0;
    mr_d     = alu_mr;
    mw_d     = alu_mw;
`ifdef EXECUTE_MUL_EN
    state_d     = state_q;
    count_d     = count_q;
    prod_d      = prod_q;
    a_d         = a_q;
    b_d         = b_q;
    mul_instr_d = mul_instr_q;
    mul_rd_d    = mul_rd_q;
    if (state_q != IDLE || opcode == OP_MUL) begin
      instr_d  = 20'd0;
      result_d = 20'd0;
      store_d  = 20'd0;
      rd_d     = 4'd0;
      rw_d     = 1'b0;
      mr_d     = 1'b0;
      mw_d     = 1'b0;
    end
    case (state_q)
      IDLE: if (opcode == OP_MUL) begin
        a_d         = fwd_a;
        b_d         = fwd_b;
        mul_instr_d = instructionPropagation;
        mul_rd_d    = opDestino;
        count_d     = 3'd0;
        prod_d      = 20'd0;
        state_d     = BUSY;
      end
      BUSY: begin
        // shift-add: BITS multiplier bits retired per cycle, low 20 bits kept
        prod_d  = prod_q + 20'(a_q * 20'(b_q[BITS-1:0]));
        a_d     = a_q << BITS;
        b_d     = b_q >> BITS;
        count_d = count_q + 3'd1;
        if (count_q == 3'(MUL_CYCLES - 1)) state_d = DONE;
      end
      DONE: begin
        instr_d  = mul_instr_q;
        result_d = prod_q;
        rd_d     = mul_rd_q;
        rw_d     = mul_rd_q != 4'd0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q  <= 20'd0;
      result_q <= 20'd0;
      store_q  <= 20'd0;
      rd_q     <= 4'd0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
`ifdef EXECUTE_MUL_EN
      state_q     <= IDLE;
      count_q     <= 3'd0;
      prod_q      <= 20'd0;
      a_q         <= 20'd0;
      b_q         <= 20'd0;
      mul_instr_q <= 20'd0;
      mul_rd_q    <= 4'd0;
`endif
    end else begin
      instr_q  <= instr_d;
      result_q <= result_d;
      store_q  <= store_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
`ifdef EXECUTE_MUL_EN
      state_q     <= state_d;
      count_q     <= count_d;
      prod_q      <= prod_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mul_instr_q <= mul_instr_d;
      mul_rd_q    <= mul_rd_d;
`endif
    end
  end

  assign EX_MEM_instruction = instr_q;
  assign EX_MEM_result      = result_q;
  assign EX_MEM_store_data  = store_q;
  assign EX_MEM_rd          = rd_q;
  assign EX_MEM_regwrite    = rw_q;
  assign EX_MEM_memread     = mr_q;
  assign EX_MEM_memwrite    = mw_q;
endmodule

// File: tb/tb_execute_ex_mem.sv
// Directed bench for execute_ex_mem: expected EX/MEM contents queued at drive
// time and compared after the capturing posedge; MUL path when EXECUTE_MUL_EN.
module tb_execute_ex_mem;
  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] instr, d1, d2, mw_data;
  logic [3:0]  op1, op2, rdst, mw_rd;
  logic        mw_rw;
  logic [19:0] o_instr, o_res, o_store;
  logic [3:0]  o_rd;
  logic        o_rw, o_mr, o_mw, stall;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [19:0] instr, result, store;
    logic [3:0]  rd;
    logic        rw, mr, mw;
    bit          chk_rd, chk_store;
  } exp_t;
  exp_t sb[$];

  execute_ex_mem #(.MUL_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .instructionPropagation(instr),
    .dataRFOut1(d1), .dataRFOut2(d2), .ID_EX_op1(op1), .ID_EX_op2(op2),
    .opDestino(rdst), .MEM_WB_rd(mw_rd), .MEM_WB_regwrite(mw_rw),
    .MEM_WB_data(mw_data), .EX_MEM_instruction(o_instr), .EX_MEM_result(o_res),
    .EX_MEM_store_data(o_store), .EX_MEM_rd(o_rd), .EX_MEM_regwrite(o_rw),
    .EX_MEM_memread(o_mr), .EX_MEM_memwrite(o_mw), .stall_out(stall));

  always #5 clock = ~clock;

  task automatic cmp(input string tag, input logic [19:0] got, input logic [19:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [19:0] i, input logic [19:0] r, input logic [19:0] s,
                              input logic [3:0] d, input logic w, input logic m_r, input logic m_w,
                              input bit cd, input bit cs);
    exp_t e;
    e.instr = i; e.result = r; e.store = s; e.rd = d;
    e.rw = w; e.mr = m_r; e.mw = m_w; e.chk_rd = cd; e.chk_store = cs;
    return e;
  endfunction

  function automatic exp_t zero_e();
    return mk(20'd0, 20'd0, 20'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endfunction

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    cmp({tag, "_instr"}, o_instr, e.instr);
    cmp({tag, "_result"}, o_res, e.result);
    cmp({tag, "_ctrl"}, {17'd0, o_rw, o_mr, o_mw}, {17'd0, e.rw, e.mr, e.mw});
    if (e.chk_rd) cmp({tag, "_rd"}, {16'd0, o_rd}, {16'd0, e.rd});
    if (e.chk_store) cmp({tag, "_store"}, o_store, e.store);
  endtask

  // inputs already set; check stall, queue expectation, capture, compare
  task automatic step(input string tag, input logic stall_exp, input exp_t e);
    #1;
    cmp({tag, "_stall"}, {19'd0, stall}, {19'd0, stall_exp});
    sb.push_back(e);
    @(posedge clock);
    #1;
    check_out(tag);
  endtask

  task automatic set_op(input logic [3:0] op, input logic [3:0] d, input logic [3:0] s1,
                        input logic [3:0] s2, input logic [3:0] im,
                        input logic [19:0] a, input logic [19:0] b);
    instr = {op, d, s1, s2, im};
    rdst = d; op1 = s1; op2 = s2; d1 = a; d2 = b;
  endtask

  initial begin
    reset = 1'b1; mw_rd = 4'd0; mw_rw = 1'b0; mw_data = 20'd0;
    set_op(4'h0, 4'd0, 4'd0, 4'd0, 4'd0, 20'd0, 20'd0);
    @(posedge clock);
    step("reset", 1'b0, zero_e());
    reset = 1'b0;

    set_op(4'h1, 4'd3, 4'd1, 4'd2, 4'd0, 20'd5, 20'd7);
    step("add", 1'b0, mk(instr, 20'd12, 20'd0, 4'd3, 1, 0, 0, 1, 0));

    // r3 from EX/MEM (12) beats MEM/WB (99); B = r1 = 5
    set_op(4'h2, 4'd4, 4'd3, 4'd1, 4'd0, 20'd0, 20'd5);
    mw_rd = 4'd3; mw_rw = 1'b1; mw_data = 20'd99;
    step("fwd_exmem", 1'b0, mk(instr, 20'd7, 20'd0, 4'd4, 1, 0, 0, 1, 0));

    set_op(4'h3, 4'd5, 4'd6, 4'd7, 4'd0, 20'd0, 20'h0FF0F);
    mw_rd = 4'd6; mw_data = 20'hF0F0F;
    step("fwd_memwb", 1'b0, mk(instr, 20'h00F0F, 20'd0, 4'd5, 1, 0, 0, 1, 0));

    set_op(4'h4, 4'd6, 4'd0, 4'd0, 4'd0, 20'h12000, 20'h00034);
    mw_rd = 4'd0; mw_data = 20'hFFFFF;
    step("r0_nofwd", 1'b0, mk(instr, 20'h12034, 20'd0, 4'd6, 1, 0, 0, 1, 0));
    mw_rw = 1'b0;

    set_op(4'h2, 4'd7, 4'd1, 4'd2, 4'd0, 20'd0, 20'd1);
    step("sub_wrap", 1'b0, mk(instr, 20'hFFFFF, 20'd0, 4'd7, 1, 0, 0, 1, 0));

    set_op(4'h5, 4'd8, 4'd1, 4'd2, 4'd0, 20'hFFFFF, 20'd1);
    step("slt_neg", 1'b0, mk(instr, 20'd1, 20'd0, 4'd8, 1, 0, 0, 1, 0));

    set_op(4'h5, 4'd9, 4'd1, 4'd2, 4'd0, 20'd1, 20'hFFFFF);
    step("slt_pos", 1'b0, mk(instr, 20'd0, 20'd0, 4'd9, 1, 0, 0, 1, 0));

    set_op(4'h8, 4'd0, 4'd1, 4'd2, 4'd3, 20'h00010, 20'hABCDE);
    step("st", 1'b0, mk(instr, 20'h00013, 20'hABCDE, 4'd0, 0, 0, 1, 0, 1));

    set_op(4'h7, 4'd10, 4'd1, 4'd2, 4'd5, 20'hFFFFE, 20'd0);
    step("ld_wrap", 1'b0, mk(instr, 20'h00003, 20'd0, 4'd10, 1, 1, 0, 1, 0));

    set_op(4'h1, 4'd0, 4'd1, 4'd2, 4'd0, 20'hFFFFF, 20'd2);
    step("add_rd0", 1'b0, mk(instr, 20'd1, 20'd0, 4'd0, 0, 0, 0, 0, 0));

    set_op(4'hA, 4'd5, 4'd1, 4'd2, 4'd0, 20'd3, 20'd4);
    step("nop_hi", 1'b0, mk(instr, 20'd0, 20'd0, 4'd0, 0, 0, 0, 0, 0));

`ifdef EXECUTE_MUL_EN
    set_op(4'h6, 4'd11, 4'd1, 4'd2, 4'd0, 20'h00123, 20'h00010);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("mul_bubble%0d", i), 1'b1, zero_e());
      d1 = $urandom; d2 = $urandom;   // must be ignored while busy
    end
    step("mul_done", 1'b0, mk(instr, 20'h01230, 20'd0, 4'd11, 1, 0, 0, 1, 0));

    set_op(4'h6, 4'd12, 4'd1, 4'd2, 4'd0, 20'hFFFFF, 20'hFFFFF);
    for (int i = 0; i < 5; i++) step($sformatf("mul2_bubble%0d", i), 1'b1, zero_e());
    step("mul2_done", 1'b0, mk(instr, 20'd1, 20'd0, 4'd12, 1, 0, 0, 1, 0));

    set_op(4'h6, 4'd13, 4'd1, 4'd2, 4'd0, 20'h00007, 20'h00003);
    step("abort_idle", 1'b1, zero_e());
    step("abort_busy1", 1'b1, zero_e());
    reset = 1'b1;
    step("abort_reset", 1'b0, zero_e());
    reset = 1'b0;
    set_op(4'h1, 4'd3, 4'd1, 4'd2, 4'd0, 20'd5, 20'd7);
    step("abort_add", 1'b0, mk(instr, 20'd12, 20'd0, 4'd3, 1, 0, 0, 1, 0));
    set_op(4'h0, 4'd0, 4'd0, 4'd0, 4'd0, 20'd0, 20'd0);
    for (int i = 0; i < 6; i++) step($sformatf("abort_quiet%0d", i), 1'b0, zero_e());
`else
    set_op(4'h6, 4'd11, 4'd1, 4'd2, 4'd0, 20'h00123, 20'h00010);
    step("mul_off", 1'b0, mk(instr, 20'd0, 20'd0, 4'd0, 0, 0, 0, 0, 0));
    step("mul_off2", 1'b0, mk(instr, 20'd0, 20'd0, 4'd0, 0, 0, 0, 0, 0));
`endif

    set_op(4'h1, 4'd3, 4'd1, 4'd2, 4'd0, 20'd5, 20'd7);
    reset = 1'b1;
    step("reset_mid", 1'b0, zero_e());
    reset = 1'b0;
    step("after_reset", 1'b0, mk(instr, 20'd12, 20'd0, 4'd3, 1, 0, 0, 1, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
